// File: rtl/bc_arbiter_if.sv
// Stream bundle shared by the two source ports and the link port of bc_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface bc_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              avoid_in_valid;
    logic              avoid_in_rdy;
    logic [DATA_W-1:0] avoid_in_data;
    logic              ctrl_in_valid;
    logic              ctrl_in_rdy;
    logic [DATA_W-1:0] ctrl_in_data;
    logic              link_out_valid;
    logic              link_out_rdy;
    logic [DATA_W-1:0] link_out_data;
    logic              link_out_src;

    modport slave (
        input  avoid_in_valid,
        input  avoid_in_data,
        output avoid_in_rdy,
        input  ctrl_in_valid,
        input  ctrl_in_data,
        output ctrl_in_rdy,
        output link_out_valid,
        output link_out_data,
        output link_out_src,
        input  link_out_rdy
    );

    modport master (
        output avoid_in_valid,
        output avoid_in_data,
        input  avoid_in_rdy,
        output ctrl_in_valid,
        output ctrl_in_data,
        input  ctrl_in_rdy,
        input  link_out_valid,
        input  link_out_data,
        input  link_out_src,
        output link_out_rdy
    );
endinterface

// File: rtl/bc_arbiter.sv
// Two-source burst arbiter: avoid and ctrl streams share one registered link,
// with bounded bursts, alternating tie-break and saturating per-source counters.
module bc_arbiter #(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    bc_arbiter_if.slave bus,
    input  logic        cnt_clr,
    output logic [15:0] avoid_cnt,
    output logic [15:0] ctrl_cnt,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_C = 2'b10
    } state_t;

    // bcnt reaching this value means the current transfer completes the burst
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t            state_r;
    logic [3:0]        bcnt_r;
    logic              last_src_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_src_r;
    logic [15:0]       avoid_cnt_r;
    logic [15:0]       ctrl_cnt_r;

    logic              load_ok_s;
    logic              avoid_rdy_s;
    logic              ctrl_rdy_s;
    logic              avoid_xfer_s;
    logic              ctrl_xfer_s;
    logic              in_xfer_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              sel_src_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    // Handshake qualification: only the granted source sees rdy, and only when the output stage can take a word
    always_comb begin
        load_ok_s   = !out_valid_r || bus.link_out_rdy;
        avoid_rdy_s = 1'b0;
        ctrl_rdy_s  = 1'b0;
        case (state_r)
            GRANT_A: avoid_rdy_s = load_ok_s;
            GRANT_C: ctrl_rdy_s  = load_ok_s;
            default: begin
                avoid_rdy_s = 1'b0;
                ctrl_rdy_s  = 1'b0;
            end
        endcase
        avoid_xfer_s = bus.avoid_in_valid && avoid_rdy_s;
        ctrl_xfer_s  = bus.ctrl_in_valid && ctrl_rdy_s;
        in_xfer_s    = avoid_xfer_s || ctrl_xfer_s;
        if (ctrl_xfer_s) begin
            sel_data_s = bus.ctrl_in_data;
            sel_src_s  = 1'b1;
        end else begin
            sel_data_s = bus.avoid_in_data;
            sel_src_s  = 1'b0;
        end
    end

    // Grant state machine with burst counter and last-served tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            bcnt_r     <= 4'd0;
            last_src_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    bcnt_r <= 4'd0;
                    if (bus.avoid_in_valid && !bus.ctrl_in_valid) begin
                        state_r <= GRANT_A;
                    end else if (bus.ctrl_in_valid && !bus.avoid_in_valid) begin
                        state_r <= GRANT_C;
                    end else if (bus.avoid_in_valid && bus.ctrl_in_valid) begin
                        // tie goes to whichever source was not served last
                        state_r <= last_src_r ? GRANT_A : GRANT_C;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT_A: begin
                    if (avoid_xfer_s) begin
                        last_src_r <= 1'b0;
                        if (bcnt_r == BURST_LAST) begin
                            bcnt_r  <= 4'd0;
                            state_r <= bus.ctrl_in_valid ? GRANT_C : GRANT_A;
                        end else begin
                            bcnt_r <= bcnt_r + 4'd1;
                        end
                    end else if (!bus.avoid_in_valid) begin
                        bcnt_r  <= 4'd0;
                        state_r <= bus.ctrl_in_valid ? GRANT_C : IDLE;
                    end else begin
                        state_r <= GRANT_A;
                    end
                end
                GRANT_C: begin
                    if (ctrl_xfer_s) begin
                        last_src_r <= 1'b1;
                        if (bcnt_r == BURST_LAST) begin
                            bcnt_r  <= 4'd0;
                            state_r <= bus.avoid_in_valid ? GRANT_A : GRANT_C;
                        end else begin
                            bcnt_r <= bcnt_r + 4'd1;
                        end
                    end else if (!bus.ctrl_in_valid) begin
                        bcnt_r  <= 4'd0;
                        state_r <= bus.avoid_in_valid ? GRANT_A : IDLE;
                    end else begin
                        state_r <= GRANT_C;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    bcnt_r  <= 4'd0;
                end
            endcase
        end
    end

    // Output stage: loads on an input transfer, otherwise drains on a link transfer and holds under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= 1'b0;
        end else if (in_xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_src_r   <= sel_src_s;
        end else if (bus.link_out_rdy) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating accepted-word counters; a clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avoid_cnt_r <= 16'd0;
            ctrl_cnt_r  <= 16'd0;
        end else if (cnt_clr) begin
            avoid_cnt_r <= 16'd0;
            ctrl_cnt_r  <= 16'd0;
        end else begin
            if (avoid_xfer_s) begin
                avoid_cnt_r <= sat_inc(avoid_cnt_r);
            end else begin
                avoid_cnt_r <= avoid_cnt_r;
            end
            if (ctrl_xfer_s) begin
                ctrl_cnt_r <= sat_inc(ctrl_cnt_r);
            end else begin
                ctrl_cnt_r <= ctrl_cnt_r;
            end
        end
    end

    assign bus.avoid_in_rdy   = avoid_rdy_s;
    assign bus.ctrl_in_rdy    = ctrl_rdy_s;
    assign bus.link_out_valid = out_valid_r;
    assign bus.link_out_data  = out_data_r;
    assign bus.link_out_src   = out_src_r;
    assign avoid_cnt          = avoid_cnt_r;
    assign ctrl_cnt           = ctrl_cnt_r;
    assign grant              = state_r;

endmodule

// File: tb/tb_bc_arbiter.sv
// Scoreboard bench for bc_arbiter: sources push accepted words into per-source
// expected queues, a monitor checks link output order, stalls and burst bounds.
`timescale 1ns/1ps
module tb_bc_arbiter;
    localparam int DW = 16;
    localparam int MB = 4;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [15:0] avoid_cnt;
    logic [15:0] ctrl_cnt;
    logic [1:0]  grant;

    bc_arbiter_if #(.DATA_W(DW)) bus ();

    bc_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
        .avoid_cnt (avoid_cnt),
        .ctrl_cnt  (ctrl_cnt),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    int          errors  = 0;
    int          checks  = 0;
    int          cyc     = 0;
    int          out_cnt = 0;
    logic        en_a    = 1'b0;
    logic        en_c    = 1'b0;
    logic        seq_on  = 1'b0;
    logic [15:0] pend_a[$];
    logic [15:0] pend_c[$];
    logic [15:0] exp_a[$];
    logic [15:0] exp_c[$];
    logic [16:0] seq_q[$];
    logic [15:0] m_cnt_a = 16'd0;
    logic [15:0] m_cnt_c = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Source drivers: present queue heads, retire accepted words into the expected queues
    initial begin : drv
        logic fa, fc, clr;
        bus.avoid_in_valid = 1'b1;
        bus.avoid_in_data  = 16'hBEEF;
        bus.ctrl_in_valid  = 1'b1;
        bus.ctrl_in_data   = 16'h5A5A;
        forever begin
            @(negedge clk);
            fa  = bus.avoid_in_valid && bus.avoid_in_rdy;
            fc  = bus.ctrl_in_valid && bus.ctrl_in_rdy;
            clr = cnt_clr;
            @(posedge clk);
            #1;
            if (fa) exp_a.push_back(pend_a.pop_front());
            if (fc) exp_c.push_back(pend_c.pop_front());
            if (clr) begin
                m_cnt_a = 16'd0;
                m_cnt_c = 16'd0;
            end else begin
                if (fa && m_cnt_a != 16'hFFFF) m_cnt_a = m_cnt_a + 16'd1;
                if (fc && m_cnt_c != 16'hFFFF) m_cnt_c = m_cnt_c + 16'd1;
            end
            bus.avoid_in_valid = en_a && (pend_a.size() > 0);
            if (pend_a.size() > 0) bus.avoid_in_data = pend_a[0];
            else bus.avoid_in_data = 16'($urandom);
            bus.ctrl_in_valid = en_c && (pend_c.size() > 0);
            if (pend_c.size() > 0) bus.ctrl_in_data = pend_c[0];
            else bus.ctrl_in_data = 16'($urandom);
        end
    end

    // Monitor: link word order, stall stability, rdy exclusivity, burst bound while the other source waits
    initial begin : mon
        logic [15:0] hold_d;
        logic        hold_s, hold_v, fa, fc;
        int          run_a, run_c;
        hold_v = 1'b0; hold_d = 16'd0; hold_s = 1'b0;
        run_a = 0; run_c = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0; run_a = 0; run_c = 0;
            end else begin
                if (hold_v) begin
                    check("stall_valid", 32'(bus.link_out_valid), 32'd1);
                    check("stall_data", 32'(bus.link_out_data), 32'(hold_d));
                    check("stall_src", 32'(bus.link_out_src), 32'(hold_s));
                end
                hold_v = bus.link_out_valid && !bus.link_out_rdy;
                hold_d = bus.link_out_data;
                hold_s = bus.link_out_src;
                if (bus.avoid_in_rdy || bus.ctrl_in_rdy)
                    check("rdy_exclusive", 32'(bus.avoid_in_rdy && bus.ctrl_in_rdy), 32'd0);
                if (bus.link_out_valid && bus.link_out_rdy) begin
                    out_cnt++;
                    if (seq_on && seq_q.size() > 0)
                        check("arb_seq", 32'({bus.link_out_src, bus.link_out_data}), 32'(seq_q.pop_front()));
                    if (bus.link_out_src && exp_c.size() > 0)
                        check("ctrl_order", 32'(bus.link_out_data), 32'(exp_c.pop_front()));
                    else if (!bus.link_out_src && exp_a.size() > 0)
                        check("avoid_order", 32'(bus.link_out_data), 32'(exp_a.pop_front()));
                    else begin
                        checks++; errors++;
                        $display("FAIL unexpected_word: actual src=%0d data=%0h required none pending",
                                 bus.link_out_src, bus.link_out_data);
                    end
                end
                fa = bus.avoid_in_valid && bus.avoid_in_rdy;
                fc = bus.ctrl_in_valid && bus.ctrl_in_rdy;
                if (!bus.ctrl_in_valid || fc) run_a = 0;
                if (!bus.avoid_in_valid || fa) run_c = 0;
                if (fa && bus.ctrl_in_valid) begin
                    run_a++;
                    check("burst_bound_a", 32'(run_a <= MB), 32'd1);
                end
                if (fc && bus.avoid_in_valid) begin
                    run_c++;
                    check("burst_bound_c", 32'(run_c <= MB), 32'd1);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic flush_model();
        pend_a.delete(); pend_c.delete(); exp_a.delete(); exp_c.delete(); seq_q.delete();
        m_cnt_a = 16'd0; m_cnt_c = 16'd0;
        en_a = 1'b0; en_c = 1'b0; seq_on = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_model();
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((pend_a.size() + pend_c.size() + exp_a.size() + exp_c.size() != 0 || bus.link_out_valid)
               && n < budget) begin
            step(1);
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_out_valid(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.link_out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.link_out_valid), 32'd1);
        #1;
    endtask

    task automatic wait_grant(input string name, input logic [1:0] g, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (grant !== g && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(grant), 32'(g));
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t0, x0;
        logic [15:0] d0;
        logic        s0;
        int id_a, id_c;
        bus.link_out_rdy = 1'b1;

        // Asynchronous reset with arbitrary inputs, before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.link_out_valid), 32'd0);
        check("rst_out_data", 32'(bus.link_out_data), 32'd0);
        check("rst_out_src", 32'(bus.link_out_src), 32'd0);
        check("rst_avoid_rdy", 32'(bus.avoid_in_rdy), 32'd0);
        check("rst_ctrl_rdy", 32'(bus.ctrl_in_rdy), 32'd0);
        check("rst_avoid_cnt", 32'(avoid_cnt), 32'd0);
        check("rst_ctrl_cnt", 32'(ctrl_cnt), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        step(2);
        rst = 1'b0;
        step(1);

        // Single source: 10 avoid words, latency 2, one per cycle
        for (int i = 0; i < 10; i++) pend_a.push_back(16'(16'h000A + i));
        en_a = 1'b1;
        @(negedge clk);
        while (!bus.avoid_in_valid) @(negedge clk);
        t0 = cyc;
        wait_out_valid("single_first_out", 10);
        check("single_latency", 32'(cyc - t0), 32'd2);
        x0 = out_cnt;
        repeat (9) @(negedge clk);
        #1;
        check("single_rate", 32'(out_cnt - x0), 32'd9);
        wait_drain("single_drain", 50);
        check("single_avoid_cnt", 32'(avoid_cnt), 32'd10);
        check("single_ctrl_cnt", 32'(ctrl_cnt), 32'd0);

        // Contention from reset: alternating bursts of MB, no idle cycles
        do_reset();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < MB; k++) begin
                pend_a.push_back(16'(16'h000A + MB * b + k));
                seq_q.push_back({1'b0, 16'(16'h000A + MB * b + k)});
            end
            for (int k = 0; k < MB; k++) begin
                pend_c.push_back(16'(16'h0014 + MB * b + k));
                seq_q.push_back({1'b1, 16'(16'h0014 + MB * b + k)});
            end
        end
        seq_on = 1'b1;
        en_a = 1'b1; en_c = 1'b1;
        wait_out_valid("cont_first_out", 10);
        x0 = out_cnt;
        repeat (31) @(negedge clk);
        #1;
        check("cont_no_bubble", 32'(out_cnt - x0), 32'd31);
        wait_drain("cont_drain", 60);
        check("cont_seq_done", 32'(seq_q.size()), 32'd0);
        check("cont_avoid_cnt", 32'(avoid_cnt), 32'd16);
        check("cont_ctrl_cnt", 32'(ctrl_cnt), 32'd16);
        seq_on = 1'b0;
        en_c = 1'b0;

        // Backpressure: link stalled while words are pending
        for (int i = 0; i < 8; i++) pend_a.push_back(16'(16'h0100 + i));
        wait_out_valid("bp_first_out", 10);
        step(1);
        bus.link_out_rdy = 1'b0;
        @(negedge clk);
        d0 = bus.link_out_data;
        s0 = bus.link_out_src;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.link_out_valid), 32'd1);
            check("bp_data", 32'(bus.link_out_data), 32'(d0));
            check("bp_src", 32'(bus.link_out_src), 32'(s0));
            check("bp_avoid_rdy", 32'(bus.avoid_in_rdy), 32'd0);
            check("bp_ctrl_rdy", 32'(bus.ctrl_in_rdy), 32'd0);
        end
        step(1);
        bus.link_out_rdy = 1'b1;
        wait_drain("bp_drain", 50);
        check("bp_avoid_cnt", 32'(avoid_cnt), 32'(m_cnt_a));

        // Source drop: avoid stops after 2 words while ctrl waits, then both idle
        do_reset();
        pend_a.push_back(16'h0201); pend_a.push_back(16'h0202);
        for (int i = 0; i < 3; i++) pend_c.push_back(16'(16'h0301 + i));
        en_a = 1'b1; en_c = 1'b1;
        wait_grant("drop_grant_a", 2'b01, 10);
        @(negedge clk);
        check("drop_grant_a_2nd", 32'(grant), 32'd1);
        @(negedge clk);
        check("drop_avoid_low", 32'(bus.avoid_in_valid), 32'd0);
        check("drop_still_a", 32'(grant), 32'd1);
        @(negedge clk);
        check("drop_switch_c", 32'(grant), 32'd2);
        wait_grant("drop_idle", 2'b00, 20);
        wait_drain("drop_drain", 20);

        // Reset mid-burst with a held output word, then arbitration restarts
        for (int i = 0; i < 6; i++) begin
            pend_a.push_back(16'(16'h0400 + i));
            pend_c.push_back(16'(16'h0500 + i));
        end
        bus.link_out_rdy = 1'b0;
        step(6);
        check("mid_pre_valid", 32'(bus.link_out_valid), 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.link_out_valid), 32'd0);
        check("mid_rst_data", 32'(bus.link_out_data), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_rdy", 32'({bus.avoid_in_rdy, bus.ctrl_in_rdy}), 32'd0);
        check("mid_rst_cnt", 32'({avoid_cnt, ctrl_cnt}), 32'd0);
        flush_model();
        bus.link_out_rdy = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        pend_a.push_back(16'h0601); pend_a.push_back(16'h0602);
        pend_c.push_back(16'h0701); pend_c.push_back(16'h0702);
        seq_q.push_back({1'b0, 16'h0601}); seq_q.push_back({1'b0, 16'h0602});
        seq_q.push_back({1'b1, 16'h0701}); seq_q.push_back({1'b1, 16'h0702});
        seq_on = 1'b1;
        en_a = 1'b1; en_c = 1'b1;
        wait_drain("restart_drain", 30);
        check("restart_seq_done", 32'(seq_q.size()), 32'd0);
        seq_on = 1'b0;

        // Random traffic, random backpressure and occasional counter clears
        id_a = 0; id_c = 0;
        for (int c = 0; c < 1500; c++) begin
            while (pend_a.size() < 3) begin pend_a.push_back(16'(id_a)); id_a++; end
            while (pend_c.size() < 3) begin pend_c.push_back(16'(16'h8000 + id_c)); id_c++; end
            en_a = ($urandom % 4) != 0;
            en_c = ($urandom % 4) != 0;
            bus.link_out_rdy = ($urandom % 3) != 0;
            cnt_clr = ($urandom % 150) == 0;
            step(1);
        end
        cnt_clr = 1'b0;
        en_a = 1'b1; en_c = 1'b1;
        bus.link_out_rdy = 1'b1;
        wait_drain("rand_drain", 100);
        check("rand_avoid_cnt", 32'(avoid_cnt), 32'(m_cnt_a));
        check("rand_ctrl_cnt", 32'(ctrl_cnt), 32'(m_cnt_c));

        // Counter saturation, then clear concurrent with a transfer
        do_reset();
        for (int i = 0; i < 65540; i++) pend_c.push_back(16'(i));
        en_c = 1'b1;
        wait_drain("sat_drain", 70000);
        check("sat_ctrl_cnt", 32'(ctrl_cnt), 32'hFFFF);
        check("sat_model", 32'(ctrl_cnt), 32'(m_cnt_c));
        for (int i = 0; i < 10; i++) pend_c.push_back(16'(16'h0900 + i));
        step(3);
        cnt_clr = 1'b1;
        @(negedge clk);
        check("clr_with_xfer", 32'(bus.ctrl_in_valid && bus.ctrl_in_rdy), 32'd1);
        step(1);
        cnt_clr = 1'b0;
        check("clr_result", 32'(ctrl_cnt), 32'd0);
        step(1);
        check("clr_then_count", 32'(ctrl_cnt), 32'(m_cnt_c));
        wait_drain("clr_drain", 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bc_arbiter.md
BC_ARBITER -- requirements
Module: bc_arbiter

Interface
REQ-001 Parameter: DATA_W, default 16, width of all data ports.
REQ-002 Parameter: MAX_BURST, default 4, range 1..15, maximum consecutive transfers granted to one source while the other waits.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: avoid_in_valid  input  1 / avoid_in_rdy  output  1 / avoid_in_data  input  DATA_W  avoidance-side source stream.
REQ-006 Port: ctrl_in_valid  input  1 / ctrl_in_rdy  output  1 / ctrl_in_data  input  DATA_W  control-side source stream.
REQ-007 Port: link_out_valid  output  1 / link_out_rdy  input  1 / link_out_data  output  DATA_W  shared link stream.
REQ-008 Port: link_out_src  output  1  source tag of link_out_data; 0=avoid, 1=ctrl.
REQ-009 Port: cnt_clr  input  1  synchronous clear of both transfer counters.
REQ-010 Port: avoid_cnt, ctrl_cnt  output  16 each  saturating count of words accepted per source.
REQ-011 Port: grant  output  2  current state: 00 IDLE, 01 GRANT_A, 10 GRANT_C.

Function
REQ-012 A transfer on any port occurs on a rising edge where valid and rdy are both 1.
REQ-013 State machine states SHALL be IDLE, GRANT_A (avoid), GRANT_C (ctrl); burst counter bcnt, 0..MAX_BURST; last-served flag last_src.
REQ-014 load_ok = !link_out_valid || link_out_rdy (combinational).
REQ-015 avoid_in_rdy = (state==GRANT_A) && load_ok; ctrl_in_rdy = (state==GRANT_C) && load_ok; non-granted rdy always 0; IDLE drives both rdy 0.
REQ-016 IDLE: only avoid valid -> GRANT_A; only ctrl valid -> GRANT_C; both valid -> grant source != last_src; neither -> stay; bcnt=0.
REQ-017 GRANT_X, transfer this cycle and bcnt+1==MAX_BURST: other valid -> GRANT_Y, bcnt=0; other not valid -> stay GRANT_X, bcnt=0.
REQ-018 GRANT_X, no transfer and X_valid=0: other valid -> GRANT_Y, else -> IDLE; bcnt=0.
REQ-019 GRANT_X otherwise: stay, bcnt increments by 1 per transfer; last_src set to X on every X transfer.
REQ-020 Output register: on input transfer, link_out_data/link_out_src load from granted source and link_out_valid=1 next cycle (1-cycle latency accept-to-output).
REQ-021 Without input transfer, link_out_valid clears on a link transfer, else holds; data/src SHALL stay stable while valid && !link_out_rdy.
REQ-022 Simultaneous link transfer and input transfer SHALL sustain one word per cycle with no bubble, including at grant switch.
REQ-023 First word from IDLE: valid at cycle N -> grant at N+1 -> accepted N+1 -> link_out_valid at N+2.
REQ-024 avoid_cnt/ctrl_cnt increment on their source's transfer, saturate at 0xFFFF; cnt_clr has priority over increment, result 0.
REQ-025 Ordering within one source SHALL be preserved; no word dropped or duplicated.

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE, bcnt=0, last_src=1 (avoid wins first tie), link_out_valid=0, link_out_data=0, link_out_src=0, both rdy=0, both counters 0, grant=00.
REQ-027 Reset mid-burst discards the output register contents; after release, arbitration restarts per REQ-016.

Verification
REQ-028 Reset: rst=1 with arbitrary inputs -> all outputs 0 per REQ-026 within the same cycle, no clock required.
REQ-029 Single source: avoid sends 0x000A..0x0013 on consecutive cycles, link_out_rdy=1 -> link emits same 10 words in order, src=0, first at +2 cycles, one per cycle, avoid_cnt=10.
REQ-030 Contention, MAX_BURST=4: avoid 0x000A.., ctrl 0x0014.. both continuously valid -> link sequence 0A,0B,0C,0D,14,15,16,17,0E,... with no idle cycles.
REQ-031 Backpressure: link_out_rdy=0 for 5 cycles with words pending -> link_out_valid=1, data/src unchanged, both in_rdy=0; after release no loss or duplication.
REQ-032 Source drop: GRANT_A, avoid_in_valid falls after 2 words while ctrl valid -> GRANT_C next cycle, bcnt=0; both sources go idle -> grant=00.
REQ-033 Counters: force 0xFFFF ctrl transfers -> ctrl_cnt holds 0xFFFF; cnt_clr pulse concurrent with transfer -> 0.
